phased_xform_rf: RTL
====================

PHASED_XFORM_RF -- requirements
Module: phased_xform_rf

Interface
REQ-001 The block SHALL have these parameters:
  - WIDTH, default 32, data width in bits.
  - DEPTH, default 4, number of storage slots; power of two, 2..256.
  - CNT_W, default 8, beat-counter width in bits; at least 3.
  - MOD_K, default 5, phase-0 modulus; nonzero, less than 2^WIDTH.
REQ-002 The block SHALL derive AW = log2(DEPTH) internally; AW is not a port or an override.
REQ-003 The block SHALL have these ports:
  - clk, input, 1, sole clock; all state changes on its rising edge.
  - reset, input, 1, synchronous, active-high.
  - in_valid, input, 1, qualifies in for this cycle.
  - in, input, WIDTH, data sample.
  - rd_addr, input, AW, read-port slot select.
  - rd_data, output, WIDTH, registered read data.
  - out, output, WIDTH, last transformed result written.
  - out_valid, output, 1, one-cycle pulse, high when out is updated.
  - phase, output, 2, phase of the most recent accepted beat.
  - cnt_o, output, CNT_W, current beat counter.

Function
REQ-004 The block SHALL accept a beat on every rising edge with in_valid=1; there is no backpressure.
REQ-005 On accept, the block SHALL capture data=in, slot=wptr and ph=f(cnt), where cnt and wptr are the pre-increment values.
REQ-006 On accept, the block SHALL increment wptr modulo DEPTH and cnt modulo 2^CNT_W.
REQ-007 With in_valid=0, wptr, cnt and phase SHALL hold.
REQ-008 The block SHALL compute the phase as follows:
  - P0 when cnt==0.
  - P1 when 1 <= cnt < 2^(CNT_W-1).
  - P2 when 2^(CNT_W-1) <= cnt < 3*2^(CNT_W-2).
  - P3 otherwise.
  - Phase is encoded 0..3 and driven on phase from the edge after accept.
REQ-009 The block SHALL apply this transform, all unsigned, result WIDTH bits:
  - P0: data % MOD_K.
  - P1: data >> 1.
  - P2: data >> 2.
  - P3: 0.
REQ-010 On the edge after accept, the block SHALL write mem[slot] <= result and out <= result, and assert out_valid for exactly that one cycle.
REQ-011 Back-to-back accepts SHALL produce back-to-back out_valid pulses, one per beat, in order.
REQ-012 Each edge, the block SHALL register rd_data <= mem[rd_addr], giving 1-cycle latency.
REQ-013 When a write and a read hit the same slot on one edge, rd_data SHALL return the pre-write contents (read-before-write).
REQ-014 cnt SHALL wrap from 2^CNT_W-1 to 0, and the beat after the wrap SHALL be P0 again.
REQ-015 wptr SHALL wrap from DEPTH-1 to 0, and later beats SHALL overwrite older slots.
REQ-016 out SHALL hold its value when out_valid=0.

Reset
REQ-017 With reset=1 at a rising edge, the block SHALL clear to 0 all of: wptr, cnt, phase, out, out_valid, rd_data, every mem slot, and any captured-but-unwritten beat.
REQ-018 Reset SHALL take priority over in_valid on the same edge; that beat is dropped.
REQ-019 A beat accepted at edge N followed by reset=1 at edge N+1 SHALL produce no write and no out_valid.
REQ-020 The first beat accepted after reset deasserts SHALL be P0, go to slot 0, and see cnt=0.

Verification
REQ-021 The bench SHALL cover these directed scenarios at default parameters:
  - Reset, then one beat in=17: next edge mem[0]=2, out=2, out_valid pulses for 1 cycle, phase=0, cnt_o=1.
  - Second beat in=17: mem[1]=8, phase=1; a third beat in=0xFFFFFFFF writes 0x7FFFFFFF to mem[2].
  - Drive 128 beats in=0, then in=0x100: phase=2, out=0x40, written to slot 0 (128 mod 4).
  - Drive 192 beats, then in=0x100: out=0, phase=3. After 256 beats cnt_o=0; beat in=12 gives out=2, phase=0.
  - Hold in_valid=0 for 5 cycles mid-stream: cnt_o, wptr and out are unchanged and out_valid stays 0. Set rd_addr to the slot being written by the beat accepted on the previous edge: rd_data shows the old value, then the new value one cycle later.
  - Accept in=17, then reset=1 on the next edge: out=0, out_valid=0, mem[0]=0. The next beat lands in slot 0 as P0.

Source files
------------

// File: rtl/phased_xform_rf.sv
// Register file that transforms accepted beats by a counter-derived phase.
// Each beat is written one edge after acceptance; reads are registered and return pre-write data.
module phased_xform_rf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8,
  parameter int MOD_K = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [WIDTH-1:0]           rd_data,
  output logic [WIDTH-1:0]           out,
  output logic                       out_valid,
  output logic [1:0]                 phase,
  output logic [CNT_W-1:0]           cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] MOD_KW = WIDTH'(MOD_K);

  localparam logic [1:0] PH_0 = 2'd0;
  localparam logic [1:0] PH_1 = 2'd1;
  localparam logic [1:0] PH_2 = 2'd2;
  localparam logic [1:0] PH_3 = 2'd3;

  logic [AW-1:0]    r_wptr;
  logic [CNT_W-1:0] r_cnt;

  logic             r_cap_valid;
  logic [WIDTH-1:0] r_cap_data;
  logic [AW-1:0]    r_cap_slot;
  logic [1:0]       r_cap_ph;

  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;
  logic [1:0]       r_phase;
  logic [WIDTH-1:0] r_rd_data;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [1:0]       w_cnt_top;
  logic [1:0]       w_phase;
  logic [WIDTH-1:0] w_result;

  // The top two counter bits split the non-zero range into the P1/P2/P3 bands.
  assign w_cnt_top = r_cnt[CNT_W-1 -: 2];

  always_comb begin
    w_phase = PH_3;
    if (r_cnt == '0) begin
      w_phase = PH_0;
    end else if (!w_cnt_top[1]) begin
      w_phase = PH_1;
    end else if (w_cnt_top == 2'b10) begin
      w_phase = PH_2;
    end
  end

  always_comb begin
    w_result = '0;
    case (r_cap_ph)
      PH_0:    w_result = r_cap_data % MOD_KW;
      PH_1:    w_result = r_cap_data >> 1;
      PH_2:    w_result = r_cap_data >> 2;
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr      <= '0;
      r_cnt       <= '0;
      r_cap_valid <= 1'b0;
      r_cap_data  <= '0;
      r_cap_slot  <= '0;
      r_cap_ph    <= PH_0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_phase     <= PH_0;
    end else begin
      r_cap_valid <= in_valid;
      if (in_valid) begin
        r_cap_data <= in;
        r_cap_slot <= r_wptr;
        r_cap_ph   <= w_phase;
        r_wptr     <= r_wptr + AW'(1);
        r_cnt      <= r_cnt + CNT_W'(1);
      end
      r_out_valid <= r_cap_valid;
      if (r_cap_valid) begin
        r_out   <= w_result;
        r_phase <= r_cap_ph;
      end
    end
  end

  // Non-blocking read of the old array contents gives read-before-write on a shared slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_rd_data <= r_mem[rd_addr];
      if (r_cap_valid) begin
        r_mem[r_cap_slot] <= w_result;
      end
    end
  end

  assign rd_data   = r_rd_data;
  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign phase     = r_phase;
  assign cnt_o     = r_cnt;

endmodule
